// File: rtl/seq_issue.sv
// seq_issue: instruction issue controller feeding the seq datapath.
// Buffers upstream instructions in a small FIFO and issues them one at a
// time, inserting a writeback hold after every push/add and holding sends
// while the UART is busy.
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | issue head of FIFO when present (sends wait on i_tx_busy)
// WB    | one-cycle writeback hold after a push/add, bus = hold_q
module seq_issue #(
  parameter int              IN_W    = 16,
  parameter int              OP_W    = 4,
  parameter int              RN_W    = 2,
  parameter int              DEPTH   = 4,
  parameter logic [OP_W-1:0] OP_PUSH = 4'h0,
  parameter logic [OP_W-1:0] OP_ADD  = 4'h1,
  parameter logic [OP_W-1:0] OP_SEND = 4'h2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] i_inst,
  input  logic            i_inst_valid,
  output logic            o_inst_ready,
  output logic [IN_W-1:0] o_inst,
  output logic            o_inst_valid,
  input  logic            i_tx_busy,
  output logic            o_idle,
  output logic [15:0]     o_stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_WB  = 1'b1;

  // Parameter sanity: pointers rely on natural wrap, fields must fit the word.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("seq_issue: DEPTH must be a power of two >= 2");
  end
  if (3 * RN_W > IN_W - OP_W) begin : g_bad_fields
    $error("seq_issue: register fields overlap the opcode");
  end

  logic [IN_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [0:0]      state;
  logic [IN_W-1:0] hold_q;

  logic            empty;
  logic            full;
  logic            wr_en;
  logic            head_live;
  logic [IN_W-1:0] head;
  logic [OP_W-1:0] opcode;
  logic            send_blocked;
  logic            pop;
  logic            wb_op;

  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign o_inst_ready = ~full;
  assign wr_en        = i_inst_valid & ~full;

  assign head      = mem[rd_ptr];
  assign opcode    = head[IN_W-1 -: OP_W];
  assign head_live = (state == ST_RUN) & ~empty;
  assign wb_op     = (opcode == OP_PUSH) | (opcode == OP_ADD);

  // Only a send can be held back; every other opcode issues unconditionally.
  assign send_blocked = head_live & (opcode == OP_SEND) & i_tx_busy;
  assign pop          = head_live & ~send_blocked;

  assign o_inst_valid = pop;
  assign o_inst       = head_live ? head : hold_q;
  assign o_idle       = (state == ST_RUN) & empty;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= i_inst;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM and the bus value held through the writeback cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RUN;
      hold_q <= '0;
    end else begin
      if (pop) hold_q <= head;
      unique case (state)
        ST_RUN:  if (pop && wb_op) state <= ST_WB;
        default: state <= ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles a send spent waiting on the UART.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_stall_cnt <= '0;
    end else if (send_blocked && o_stall_cnt != 16'hFFFF) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_seq_issue.sv
// tb_seq_issue: directed scenarios plus randomized traffic for seq_issue.
// A monitor on the falling edge compares every cycle against a queue-based
// reference model; issued instructions are checked in order against a
// scoreboard filled whenever a write is accepted.
module tb_seq_issue;

  localparam int DEPTH = 4;
  localparam logic [3:0] OP_PUSH = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SEND = 4'h2;

  logic        clk;
  logic        rst;
  logic [15:0] i_inst;
  logic        i_inst_valid;
  logic        o_inst_ready;
  logic [15:0] o_inst;
  logic        o_inst_valid;
  logic        i_tx_busy;
  logic        o_idle;
  logic [15:0] o_stall_cnt;

  seq_issue dut (
    .clk          (clk),
    .rst          (rst),
    .i_inst       (i_inst),
    .i_inst_valid (i_inst_valid),
    .o_inst_ready (o_inst_ready),
    .o_inst       (o_inst),
    .o_inst_valid (o_inst_valid),
    .i_tx_busy    (i_tx_busy),
    .o_idle       (o_idle),
    .o_stall_cnt  (o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (written only by the monitor).
  logic [15:0] mq[$];
  logic [15:0] sb[$];
  logic        m_wb    = 1'b0;
  logic [15:0] m_hold  = '0;
  logic [15:0] m_stall = '0;
  logic [15:0] vhist   = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic b);
    i_inst_valid = v;
    i_inst       = d;
    i_tx_busy    = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_inst();
    int k;
    logic [3:0] op;
    k = $urandom_range(0, 5);
    case (k)
      0:       op = OP_PUSH;
      1:       op = OP_ADD;
      2, 3:    op = OP_SEND;
      default: op = 4'($urandom_range(3, 15));
    endcase
    return {op, 12'($urandom)};
  endfunction

  // Monitor: per-cycle comparison against the model, then advance the model.
  always @(negedge clk) begin : mon
    logic [15:0] hd;
    logic        ev;
    logic [15:0] eb;
    logic        blk;
    logic        acc;
    logic [15:0] exp_i;
    if (!rst) begin
      chk("rst_valid", 32'(o_inst_valid), 32'd0);
      chk("rst_inst",  32'(o_inst),       32'd0);
      chk("rst_ready", 32'(o_inst_ready), 32'd1);
      chk("rst_idle",  32'(o_idle),       32'd1);
      chk("rst_stall", 32'(o_stall_cnt),  32'd0);
      mq.delete();
      sb.delete();
      m_wb    = 1'b0;
      m_hold  = '0;
      m_stall = '0;
      vhist   = {vhist[14:0], o_inst_valid};
    end else begin
      blk = 1'b0;
      ev  = 1'b0;
      eb  = m_hold;
      hd  = '0;
      if (!m_wb && mq.size() > 0) begin
        hd  = mq[0];
        blk = (hd[15:12] == OP_SEND) && i_tx_busy;
        ev  = !blk;
        eb  = hd;
      end
      acc = (mq.size() < DEPTH);
      chk("ready", 32'(o_inst_ready), 32'(acc));
      chk("idle",  32'(o_idle),       32'(!m_wb && mq.size() == 0));
      chk("valid", 32'(o_inst_valid), 32'(ev));
      chk("bus",   32'(o_inst),       32'(eb));
      chk("stall", 32'(o_stall_cnt),  32'(m_stall));
      vhist = {vhist[14:0], o_inst_valid};
      if (o_inst_valid) begin
        if (sb.size() == 0) begin
          chk("issue_unexpected", 32'(o_inst), 32'hFFFF_FFFF);
        end else begin
          exp_i = sb.pop_front();
          chk("issue_order", 32'(o_inst), 32'(exp_i));
        end
      end
      if (ev) begin
        m_hold = hd;
        m_wb   = (hd[15:12] == OP_PUSH) || (hd[15:12] == OP_ADD);
        void'(mq.pop_front());
      end else begin
        m_wb = 1'b0;
      end
      if (blk && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (i_inst_valid && acc) begin
        mq.push_back(i_inst);
        sb.push_back(i_inst);
      end
    end
  end

  initial begin
    // Reset held with a valid instruction on the input: nothing is written.
    rst          = 1'b0;
    i_inst_valid = 1'b1;
    i_inst       = 16'h0123;
    i_tx_busy    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b1;
    i_inst_valid = 1'b0;

    // push r0,#5; push r1,#7; add r0,r1->r2; send r2
    cyc(1'b1, 16'h0005, 1'b0);
    cyc(1'b1, 16'h0017, 1'b0);
    cyc(1'b1, 16'h1006, 1'b0);
    cyc(1'b1, 16'h2020, 1'b0);
    repeat (4) cyc(1'b0, 16'h0000, 1'b0);
    chk("push_spacing", 32'(vhist[6:0]), 32'(7'b1010101));
    repeat (2) cyc(1'b0, 16'h0000, 1'b0);
    chk("idle_after_spacing", 32'(o_idle), 32'd1);

    // Send held by busy for three cycles.
    cyc(1'b1, 16'h2030, 1'b0);
    repeat (3) cyc(1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("busy_pattern", 32'(vhist[4:0]), 32'(5'b00001));
    chk("busy_stall_cnt", 32'(o_stall_cnt), 32'd3);

    // Fill behind a blocked send, then drain across the pointer wrap.
    cyc(1'b1, 16'h2010, 1'b1);
    cyc(1'b1, 16'h00A1, 1'b1);
    cyc(1'b1, 16'h00B2, 1'b1);
    cyc(1'b1, 16'h00C3, 1'b1);
    chk("full_ready", 32'(o_inst_ready), 32'd0);
    cyc(1'b1, 16'h00D4, 1'b1);
    cyc(1'b1, 16'h00D4, 1'b0);
    cyc(1'b1, 16'h00D4, 1'b0);
    cyc(1'b1, 16'h30E5, 1'b0);
    repeat (10) cyc(1'b0, 16'h0000, 1'b0);
    chk("wrap_drained", 32'(sb.size()), 32'd0);

    // Reset during a writeback cycle with three entries buffered.
    cyc(1'b1, 16'h2011, 1'b1);
    cyc(1'b1, 16'h0021, 1'b1);
    cyc(1'b1, 16'h0032, 1'b1);
    cyc(1'b1, 16'h0043, 1'b1);
    cyc(1'b1, 16'h0054, 1'b0);
    cyc(1'b1, 16'h0054, 1'b0);
    i_inst_valid = 1'b0;
    rst          = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_inst_valid), 32'd0);
    chk("midrst_inst",  32'(o_inst),       32'd0);
    chk("midrst_ready", 32'(o_inst_ready), 32'd1);
    chk("midrst_idle",  32'(o_idle),       32'd1);
    chk("midrst_stall", 32'(o_stall_cnt),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) cyc(1'b0, 16'h0000, 1'b0);
    chk("post_reset_quiet", 32'(vhist[3:0]), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 6), rnd_inst(), ($urandom_range(0, 2) == 0));
    end
    repeat (12) cyc(1'b0, 16'h0000, 1'b0);
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
